// File: rtl/rst_ctrl_if.sv
// Wishbone classic bus bundle between a bus master and the reset controller's
// register slave. Clock and reset stay outside as plain ports.
interface rst_ctrl_if #(
  parameter int GRL = 1
);
  logic [31:0]  dat_m2s;
  logic [31:0]  adr_m2s;
  logic [GRL:0] sel_m2s;
  logic         cyc_m2s;
  logic         stb_m2s;
  logic         we_m2s;
  logic [31:0]  dat_s2m;
  logic         ack_s2m;
  logic         err_s2m;

  modport master (
    output dat_m2s, adr_m2s, sel_m2s, cyc_m2s, stb_m2s, we_m2s,
    input  dat_s2m, ack_s2m, err_s2m
  );

  modport slave (
    input  dat_m2s, adr_m2s, sel_m2s, cyc_m2s, stb_m2s, we_m2s,
    output dat_s2m, ack_s2m, err_s2m
  );
endinterface

// File: rtl/rst_ctrl.sv
// Reset controller: merges pin, software, IWDG and WWDG reset requests into
// one stretched active-low system reset and keeps sticky reset-cause flags
// that firmware reads and clears over a Wishbone slave port. Lives in the
// always-on domain and is reset only by rst_m2s.
module rst_ctrl #(
  parameter int          GRL         = 1,
  parameter logic [31:0] BASE_ADR    = 32'h0100_0100,
  parameter logic [31:0] RCC_CSR_ADR = BASE_ADR + 32'h0,
  parameter logic [31:0] RCC_SWR_ADR = BASE_ADR + 32'h4,
  parameter int          STRETCH     = 16
) (
  input  logic       clk_m2s,
  input  logic       rst_m2s,
  rst_ctrl_if.slave  wb,
  input  logic       rst_iwdg,
  input  logic       rst_wwdg,
  input  logic       pin_rst_n,
  output logic       sys_rst_n,
  output logic [4:0] rst_cause
);

  localparam logic [15:0] CNT_INIT = 16'(STRETCH - 1);
  localparam logic [31:0] SW_KEY   = 32'h0000_5FA5;
  localparam int          RMVF_BIT = 24;

  // Flag bit positions inside the CSR.
  localparam int F_PIN  = 0;
  localparam int F_SFT  = 1;
  localparam int F_IWDG = 2;
  localparam int F_WWDG = 3;
  localparam int F_POR  = 4;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,  // system running, sys_rst_n high
    ST_HOLD = 2'b01,  // minimum stretch window, counter running
    ST_WAIT = 2'b10   // stretch done, a request is still pending
  } state_e;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [1:0]  pin_sync_q;          // [0] first stage, [1] second stage
  state_e      state_q,     state_d;
  logic [15:0] cnt_q,       cnt_d;
  logic        sys_rst_n_q, sys_rst_n_d;
  logic [4:0]  flags_q,     flags_d;
  logic        ack_q,       ack_d;
  logic        err_q,       err_d;
  logic [31:0] dat_q,       dat_d;

  // ---------------------------------------------------------------------------
  // Bus decode and request conditioning
  // ---------------------------------------------------------------------------
  logic resp;
  logic hit_csr;
  logic hit_swr;
  logic mapped;
  logic rmvf;
  logic pin_req;
  logic sw_req;
  logic any_req;
  logic [4:0] flag_set;

  // Byte selects carry no meaning here; every access is a full word.
  logic [GRL:0] sel_unused;
  assign sel_unused = wb.sel_m2s;

  // A new access is accepted only while no response is on the bus, which
  // turns a held strobe into one response every second cycle.
  assign resp    = wb.cyc_m2s & wb.stb_m2s & ~ack_q & ~err_q;
  assign hit_csr = (wb.adr_m2s == RCC_CSR_ADR);
  assign hit_swr = (wb.adr_m2s == RCC_SWR_ADR);
  assign mapped  = hit_csr | hit_swr;

  // The key write and the flag clear both act on the same edge as the ack.
  assign sw_req  = resp & wb.we_m2s & hit_swr & (wb.dat_m2s == SW_KEY);
  assign rmvf    = resp & wb.we_m2s & hit_csr & wb.dat_m2s[RMVF_BIT];

  assign pin_req = ~pin_sync_q[1];
  assign any_req = pin_req | sw_req | rst_iwdg | rst_wwdg;

  always_comb begin
    flag_set         = '0;
    flag_set[F_PIN]  = pin_req;
    flag_set[F_SFT]  = sw_req;
    flag_set[F_IWDG] = rst_iwdg;
    flag_set[F_WWDG] = rst_wwdg;
    flag_set[F_POR]  = 1'b0;
  end

  // Bring the asynchronous reset pin into the clock domain through two flops.
  always_ff @(posedge clk_m2s) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_m2s) begin
      pin_sync_q <= 2'b11;
    end else begin
      pin_sync_q <= {pin_sync_q[0], pin_rst_n};
    end
  end

  // ---------------------------------------------------------------------------
  // Reset-stretch state machine
  // ---------------------------------------------------------------------------

  // Next state and counter; the output flop follows the current state so
  // sys_rst_n lags the state by one cycle and is glitch-free.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    sys_rst_n_d = (state_q == ST_RUN);

    case (state_q)
      ST_RUN: begin
        if (any_req) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_INIT;
        end
      end
      ST_HOLD: begin
        // Requests arriving here do not reload the counter.
        if (cnt_q == 16'd0) begin
          state_d = any_req ? ST_WAIT : ST_RUN;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_WAIT: begin
        if (!any_req) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        // Recover from a corrupted encoding by asserting a full reset.
        state_d = ST_HOLD;
        cnt_d   = CNT_INIT;
      end
    endcase
  end

  // State register, stretch counter and registered reset output.
  always_ff @(posedge clk_m2s) begin
    if (!rst_m2s) begin
      state_q     <= ST_HOLD;
      cnt_q       <= CNT_INIT;
      sys_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sys_rst_n_q <= sys_rst_n_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Reset-cause flags
  // ---------------------------------------------------------------------------

  // Clear is applied first so a request in the same cycle keeps its flag.
  always_comb begin
    flags_d = rmvf ? 5'b00000 : flags_q;
    flags_d = flags_d | flag_set;
  end

  // Sticky flags; power-on leaves only the POR cause set.
  always_ff @(posedge clk_m2s) begin
    if (!rst_m2s) begin
      flags_q <= 5'b10000;
    end else begin
      flags_q <= flags_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Wishbone slave response
  // ---------------------------------------------------------------------------

  // Registered single-cycle response; read data holds between responses.
  always_comb begin
    ack_d = resp & mapped;
    err_d = resp & ~mapped;
    dat_d = dat_q;
    if (resp) begin
      dat_d = (hit_csr && !wb.we_m2s) ? {27'd0, flags_q} : 32'd0;
    end
  end

  // Response flops for ack, err and read data.
  always_ff @(posedge clk_m2s) begin
    if (!rst_m2s) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= 32'd0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      dat_q <= dat_d;
    end
  end

  assign wb.ack_s2m = ack_q;
  assign wb.err_s2m = err_q;
  assign wb.dat_s2m = dat_q;
  assign sys_rst_n  = sys_rst_n_q;
  assign rst_cause  = flags_q;

endmodule

// File: tb/tb_rst_ctrl.sv
// Self-checking bench for rst_ctrl: directed scenarios followed by random
// traffic, all compared every cycle against a timestamp-based reference model.
module tb_rst_ctrl;

  localparam logic [31:0] BASE    = 32'h0100_0100;
  localparam logic [31:0] CSR     = BASE + 32'h0;
  localparam logic [31:0] SWR     = BASE + 32'h4;
  localparam logic [31:0] KEY     = 32'h0000_5FA5;
  localparam logic [31:0] RMVF    = 32'h0100_0000;
  localparam int          STRETCH = 16;

  logic       clk_m2s = 1'b0;
  logic       rst_m2s;
  logic       rst_iwdg;
  logic       rst_wwdg;
  logic       pin_rst_n;
  logic       sys_rst_n;
  logic [4:0] rst_cause;

  rst_ctrl_if #(.GRL(1)) wb ();

  rst_ctrl #(
    .GRL         (1),
    .BASE_ADR    (BASE),
    .RCC_CSR_ADR (CSR),
    .RCC_SWR_ADR (SWR),
    .STRETCH     (STRETCH)
  ) dut (
    .clk_m2s   (clk_m2s),
    .rst_m2s   (rst_m2s),
    .wb        (wb),
    .rst_iwdg  (rst_iwdg),
    .rst_wwdg  (rst_wwdg),
    .pin_rst_n (pin_rst_n),
    .sys_rst_n (sys_rst_n),
    .rst_cause (rst_cause)
  );

  always #5 clk_m2s = ~clk_m2s;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model. The system is "in reset" from the edge a request is
  // seen until the first request-free edge at least STRETCH edges later;
  // sys_rst_n shows that one edge late.
  int          edge_n;
  bit          m_in_reset;
  int          m_start;
  logic        m_sys;
  logic [4:0]  m_flags;
  logic        m_ack;
  logic        m_err;
  logic [31:0] m_dat;
  logic [1:0]  m_pin_dly;   // pin samples from one and two edges back

  task automatic model_edge();
    logic       pin_req, sw_req, any_req, resp, clr;
    logic [4:0] set;
    if (!rst_m2s) begin
      m_in_reset = 1'b1;
      m_start    = edge_n;
      m_sys      = 1'b0;
      m_flags    = 5'b10000;
      m_ack      = 1'b0;
      m_err      = 1'b0;
      m_dat      = 32'd0;
      m_pin_dly  = 2'b11;
    end else begin
      pin_req = ~m_pin_dly[1];
      resp    = wb.cyc_m2s & wb.stb_m2s & ~m_ack & ~m_err;
      sw_req  = resp & wb.we_m2s & (wb.adr_m2s == SWR) & (wb.dat_m2s == KEY);
      clr     = resp & wb.we_m2s & (wb.adr_m2s == CSR) & wb.dat_m2s[24];
      any_req = pin_req | sw_req | rst_iwdg | rst_wwdg;

      m_sys = !m_in_reset;
      if (!m_in_reset) begin
        if (any_req) begin
          m_in_reset = 1'b1;
          m_start    = edge_n;
        end
      end else if (edge_n >= m_start + STRETCH && !any_req) begin
        m_in_reset = 1'b0;
      end

      if (resp) m_dat = (wb.adr_m2s == CSR && !wb.we_m2s) ? {27'd0, m_flags} : 32'd0;
      set     = {1'b0, rst_wwdg, rst_iwdg, sw_req, pin_req};
      m_flags = (clr ? 5'd0 : m_flags) | set;
      m_ack   = resp & ((wb.adr_m2s == CSR) | (wb.adr_m2s == SWR));
      m_err   = resp & ~((wb.adr_m2s == CSR) | (wb.adr_m2s == SWR));
      m_pin_dly = {m_pin_dly[0], pin_rst_n};
    end
    edge_n++;
  endtask

  // One clock: advance the model on the edge, compare all outputs 1 ns later.
  task automatic step();
    @(posedge clk_m2s);
    model_edge();
    #1;
    check("sys_rst_n", 32'(sys_rst_n), 32'(m_sys));
    check("rst_cause", 32'(rst_cause), 32'(m_flags));
    check("ack_s2m",   32'(wb.ack_s2m), 32'(m_ack));
    check("err_s2m",   32'(wb.err_s2m), 32'(m_err));
    check("dat_s2m",   wb.dat_s2m, m_dat);
  endtask

  // Count edges after which sys_rst_n is low, stopping at the first high
  // after a low run or after max_steps.
  task automatic measure_low(input string tag, input int exp_len, input int max_steps);
    int n = 0;
    for (int k = 0; k < max_steps; k++) begin
      step();
      if (!sys_rst_n) n++;
      else if (n > 0) break;
    end
    check(tag, 32'(n), 32'(exp_len));
  endtask

  // Drive watchdog request(s) for len edges while measuring the low time.
  task automatic req_pulse(input bit i, input bit w, input int len,
                           input string tag, input int exp_len);
    int n = 0;
    rst_iwdg = i;
    rst_wwdg = w;
    for (int k = 0; k < 400; k++) begin
      step();
      if (k == len - 1) begin
        rst_iwdg = 1'b0;
        rst_wwdg = 1'b0;
      end
      if (!sys_rst_n) n++;
      else if (n > 0) break;
    end
    check(tag, 32'(n), 32'(exp_len));
  endtask

  task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                          output logic [31:0] rdat, output logic got_ack, output logic got_err);
    wb.cyc_m2s = 1'b1;
    wb.stb_m2s = 1'b1;
    wb.we_m2s  = we;
    wb.adr_m2s = adr;
    wb.dat_m2s = wdat;
    got_ack = 1'b0;
    got_err = 1'b0;
    rdat    = 32'd0;
    for (int k = 0; k < 8 && !(got_ack || got_err); k++) begin
      step();
      got_ack = wb.ack_s2m;
      got_err = wb.err_s2m;
      rdat    = wb.dat_s2m;
    end
    wb.cyc_m2s = 1'b0;
    wb.stb_m2s = 1'b0;
    wb.we_m2s  = 1'b0;
    if (!(got_ack || got_err)) check("bus_timeout", 32'd0, 32'd1);
  endtask

  task automatic rd(input logic [31:0] adr, input string tag, input logic [31:0] exp);
    logic [31:0] d;
    logic        a, e;
    bus_xfer(1'b0, adr, 32'd0, d, a, e);
    check(tag, d, exp);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] data);
    logic [31:0] d;
    logic        a, e;
    bus_xfer(1'b1, adr, data, d, a, e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] d;
    logic        a, e;
    int          acks;
    logic [31:0] adr_tab [4];
    adr_tab[0] = CSR;
    adr_tab[1] = SWR;
    adr_tab[2] = BASE + 32'h8;
    adr_tab[3] = BASE + 32'hC;

    edge_n     = 0;
    rst_m2s    = 1'b0;
    rst_iwdg   = 1'b0;
    rst_wwdg   = 1'b0;
    pin_rst_n  = 1'b1;
    wb.cyc_m2s = 1'b0;
    wb.stb_m2s = 1'b0;
    wb.we_m2s  = 1'b0;
    wb.adr_m2s = 32'd0;
    wb.dat_m2s = 32'd0;
    wb.sel_m2s = 2'b11;

    // Power-on reset held 3 cycles, then exactly STRETCH low cycles.
    for (int k = 0; k < 3; k++) step();
    check("por_flags", 32'(rst_cause), 32'h10);
    rst_m2s = 1'b1;
    measure_low("por_low_len", STRETCH, 100);
    rd(CSR, "por_csr", 32'h0000_0010);

    // IWDG one-cycle pulse: one stretch, IWDG flag joins POR flag.
    req_pulse(1'b1, 1'b0, 1, "iwdg_low_len", STRETCH);
    rd(CSR, "iwdg_csr", 32'h0000_0014);
    wr(CSR, RMVF);
    rd(CSR, "rmvf_csr", 32'h0000_0000);

    // Long WWDG request: held in reset for as long as it stays high.
    req_pulse(1'b0, 1'b1, 40, "wwdg_long_len", (40 > STRETCH) ? 40 : STRETCH);
    rd(CSR, "wwdg_csr", 32'h0000_0008);

    // Software key: wrong value ignored, correct value resets.
    wr(SWR, 32'h0000_1234);
    measure_low("swr_bad_key", 0, 20);
    wr(SWR, KEY);
    measure_low("swr_key_len", STRETCH, 100);
    rd(CSR, "swr_csr", 32'h0000_000A);
    rd(SWR, "swr_read", 32'h0000_0000);
    wr(CSR, RMVF);

    // Pin and IWDG on the same edge as an RMVF write: set beats clear.
    pin_rst_n = 1'b0;
    step();
    pin_rst_n = 1'b1;
    step();
    rst_iwdg = 1'b1;
    bus_xfer(1'b1, CSR, RMVF, d, a, e);
    rst_iwdg = 1'b0;
    check("pin_iwdg_ack", 32'(a), 32'd1);
    measure_low("pin_iwdg_len", STRETCH, 100);
    rd(CSR, "pin_iwdg_csr", 32'h0000_0005);

    // Unmapped access: error, no ack, flags untouched.
    bus_xfer(1'b0, BASE + 32'h8, 32'd0, d, a, e);
    check("unmapped_err", 32'(e), 32'd1);
    check("unmapped_ack", 32'(a), 32'd0);
    rd(CSR, "unmapped_csr", 32'h0000_0005);

    // Back-to-back reads with strobe held: one ack every two cycles.
    acks = 0;
    wb.cyc_m2s = 1'b1;
    wb.stb_m2s = 1'b1;
    wb.we_m2s  = 1'b0;
    wb.adr_m2s = CSR;
    for (int k = 0; k < 6; k++) begin
      step();
      if (wb.ack_s2m) acks++;
    end
    wb.cyc_m2s = 1'b0;
    wb.stb_m2s = 1'b0;
    check("b2b_acks", 32'(acks), 32'd3);
    step();

    // rst_m2s pulsed mid-HOLD restarts the full stretch.
    rst_iwdg = 1'b1;
    step();
    rst_iwdg = 1'b0;
    for (int k = 0; k < 5; k++) step();
    rst_m2s = 1'b0;
    step();
    rst_m2s = 1'b1;
    measure_low("por_mid_hold_len", STRETCH, 100);
    rd(CSR, "por_mid_hold_csr", 32'h0000_0010);

    // Random traffic on every input, compared cycle by cycle.
    for (int c = 0; c < 1500; c++) begin
      rst_m2s   = ($urandom_range(0, 399) != 0);
      rst_iwdg  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 59) == 0) rst_wwdg = ~rst_wwdg;
      pin_rst_n = ($urandom_range(0, 79) != 0);
      wb.cyc_m2s = ($urandom_range(0, 1) == 1);
      wb.stb_m2s = wb.cyc_m2s & ($urandom_range(0, 3) != 0);
      wb.we_m2s  = ($urandom_range(0, 1) == 1);
      wb.adr_m2s = adr_tab[$urandom_range(0, 3)];
      case ($urandom_range(0, 3))
        0:       wb.dat_m2s = KEY;
        1:       wb.dat_m2s = RMVF;
        2:       wb.dat_m2s = 32'h0000_1234;
        default: wb.dat_m2s = $urandom;
      endcase
      step();
    end
    rst_m2s    = 1'b1;
    rst_iwdg   = 1'b0;
    rst_wwdg   = 1'b0;
    pin_rst_n  = 1'b1;
    wb.cyc_m2s = 1'b0;
    wb.stb_m2s = 1'b0;
    for (int k = 0; k < 100; k++) step();
    check("final_sys_rst_n", 32'(sys_rst_n), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
